// File: rtl/hex_display_scanner_pkg.sv
// -----------------------------------------------------------------------------
// hex_display_scanner_pkg
//
// Shared constants for the debug hex display scanner:
//   - active-low seven-segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
//   - SEG_BLANK, the all-segments-off pattern
//   - DIGIT_COUNT, the number of time-multiplexed digits on the board
// -----------------------------------------------------------------------------
package hex_display_scanner_pkg;

    localparam int DIGIT_COUNT = 8;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_display_scanner_seg_decoder.sv
// -----------------------------------------------------------------------------
// hex_seg_decoder
//
// Purely combinational nibble to active-low seven-segment pattern decoder.
//
// Ports:
//   nibble  in  4  hex value to display
//   seg_n   out 7  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_seg_decoder
    import hex_display_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (nibble)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = SEG_A;
            4'hB: seg_n = SEG_B;
            4'hC: seg_n = SEG_C;
            4'hD: seg_n = SEG_D;
            4'hE: seg_n = SEG_E;
            4'hF: seg_n = SEG_F;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_scanner.sv
// -----------------------------------------------------------------------------
// hex_display_scanner
//
// Drives eight time-multiplexed, active-low seven-segment digits from a 32-bit
// debug word. The word is latched only at frame boundaries (digit 7 -> digit 0
// wrap) so a single frame never mixes nibbles of two different words.
//
// Parameters:
//   SCAN_DIV          clock cycles each digit stays lit (>= 1)
//
// Ports:
//   Clock             in  1   system clock, rising edge
//   Reset             in  1   synchronous active-high reset
//   HexDisplay32Bits  in  32  word to display; digit k shows bits [4k+3:4k]
//   Hold              in  1   at a frame boundary, keep the current word
//   Seg_n             out 7   active-low segments {g,f,e,d,c,b,a}
//   Digit_n           out 8   one-hot active-low digit enable
//   Frame_Done        out 1   one-cycle pulse at the start of each frame
//   Shown_Word        out 32  word currently being scanned
//
// Optional feature macro: HEX_LEADING_ZERO_BLANK_EN
//   When defined, digits k >= 1 whose nibble and all higher nibbles are zero
//   show SEG_BLANK. Digit 0 is never blanked and Digit_n keeps scanning.
// -----------------------------------------------------------------------------
module hex_display_scanner
    import hex_display_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 50000
)
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] HexDisplay32Bits,
    input  logic        Hold,
    output logic [6:0]  Seg_n,
    output logic [7:0]  Digit_n,
    output logic        Frame_Done,
    output logic [31:0] Shown_Word
);

    // Prescaler width, never below one bit so SCAN_DIV=1 still elaborates.
    localparam int              PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   P_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] p_reg, p_next;
    logic [2:0]    d_reg, d_next;
    logic [31:0]   word_reg, word_next;
    logic [6:0]    seg_reg, seg_next;
    logic [7:0]    digit_reg, digit_next;
    logic          frame_reg, frame_next;

    logic          p_wrap;
    logic          boundary;
    logic [3:0]    nibble;
    logic [6:0]    seg_decoded;
    logic          blank;

    // -------------------------------------------------------------------------
    // Next-state logic. Outputs are computed from the *next* digit index and
    // word so the registered outputs line up with d_reg/word_reg; the new
    // word's digit 0 therefore appears on the very edge that latches it.
    // -------------------------------------------------------------------------
    always_comb begin
        p_wrap    = (p_reg == P_MAX);
        p_next    = p_wrap ? '0 : p_reg + 1'b1;
        d_next    = p_wrap ? d_reg + 3'd1 : d_reg;
        boundary  = p_wrap && (d_reg == 3'd7);
        word_next = (boundary && !Hold) ? HexDisplay32Bits : word_reg;
        nibble    = word_next[{d_next, 2'b00} +: 4];
        seg_next  = blank ? SEG_BLANK : seg_decoded;
        frame_next = boundary;
    end

    hex_seg_decoder u_seg_decoder (
        .nibble (nibble),
        .seg_n  (seg_decoded)
    );

    // One-hot active-low digit enable for the next digit index.
    generate
        for (genvar gi = 0; gi < DIGIT_COUNT; gi++) begin : g_digit_en
            assign digit_next[gi] = (d_next != 3'(gi));
        end
    endgenerate

`ifdef HEX_LEADING_ZERO_BLANK_EN
    // upper_zero[k] is set when nibble k and every nibble above it are zero,
    // i.e. digit k would only be a leading zero.
    logic [DIGIT_COUNT-1:0] upper_zero;

    generate
        for (genvar gi = 0; gi < DIGIT_COUNT; gi++) begin : g_upper_zero
            assign upper_zero[gi] = ~|word_next[DIGIT_COUNT*4-1 : gi*4];
        end
    endgenerate

    // Digit 0 always shows something, even for an all-zero word.
    assign blank = (d_next != 3'd0) && upper_zero[d_next];
`else
    assign blank = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State and output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            p_reg     <= '0;
            d_reg     <= 3'd0;
            word_reg  <= 32'd0;
            seg_reg   <= SEG_0;
            digit_reg <= 8'hFE;
            frame_reg <= 1'b0;
        end else begin
            p_reg     <= p_next;
            d_reg     <= d_next;
            word_reg  <= word_next;
            seg_reg   <= seg_next;
            digit_reg <= digit_next;
            frame_reg <= frame_next;
        end
    end

    assign Seg_n      = seg_reg;
    assign Digit_n    = digit_reg;
    assign Frame_Done = frame_reg;
    assign Shown_Word = word_reg;

endmodule

// File: tb/tb_hex_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_hex_display_scanner
//
// Directed bench for hex_display_scanner with SCAN_DIV=4 (32-cycle frames).
// A table of {edges to advance, expected outputs} covers the first frames
// after reset; hand-written sequences cover Hold, free-running frames,
// mid-frame reset, reset on a boundary edge and leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_hex_display_scanner;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 8 * SCAN_DIV;

    logic        Clock;
    logic        Reset;
    logic [31:0] HexDisplay32Bits;
    logic        Hold;
    logic [6:0]  Seg_n;
    logic [7:0]  Digit_n;
    logic        Frame_Done;
    logic [31:0] Shown_Word;

    int checks = 0;
    int errors = 0;

    hex_display_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .HexDisplay32Bits (HexDisplay32Bits),
        .Hold             (Hold),
        .Seg_n            (Seg_n),
        .Digit_n          (Digit_n),
        .Frame_Done       (Frame_Done),
        .Shown_Word       (Shown_Word)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        int          ticks;
        logic [7:0]  digit;
        logic [6:0]  seg;
        logic [31:0] shown;
        logic        fd;
    } vec_t;

    vec_t vecs[7];

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Active-low seven-segment encoding table.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    initial begin
        logic [7:0]  one_hot;
        logic [7:0]  exp_digit;
        logic [31:0] word;
        logic [3:0]  nib;
        logic [6:0]  lead_exp;
        int          k;
        int          pulses;
        int          last_pulse;

`ifdef HEX_LEADING_ZERO_BLANK_EN
        lead_exp = 7'h7F;
`else
        lead_exp = 7'h40;
`endif

        // Table: edges advanced since the previous row, then expected outputs.
        vecs[0] = '{ticks: 1,  digit: 8'hFE, seg: 7'h40, shown: 32'h0,        fd: 1'b0};
        vecs[1] = '{ticks: 3,  digit: 8'hFD, seg: 7'h40, shown: 32'h0,        fd: 1'b0};
        vecs[2] = '{ticks: 28, digit: 8'hFE, seg: 7'h00, shown: 32'h12345678, fd: 1'b1};
        vecs[3] = '{ticks: 1,  digit: 8'hFE, seg: 7'h00, shown: 32'h12345678, fd: 1'b0};
        vecs[4] = '{ticks: 3,  digit: 8'hFD, seg: 7'h78, shown: 32'h12345678, fd: 1'b0};
        vecs[5] = '{ticks: 24, digit: 8'h7F, seg: 7'h79, shown: 32'h12345678, fd: 1'b0};
        vecs[6] = '{ticks: 4,  digit: 8'hFE, seg: 7'h00, shown: 32'h12345678, fd: 1'b1};

        // ---- Reset values ----
        Reset = 1'b1;
        Hold = 1'b0;
        HexDisplay32Bits = 32'h12345678;
        tick(2);
        check("reset_digit", {24'd0, Digit_n}, 32'hFE);
        check("reset_seg",   {25'd0, Seg_n},   32'h40);
        check("reset_shown", Shown_Word,       32'h0);
        check("reset_fd",    {31'd0, Frame_Done}, 32'h0);
        $display("reset: Digit_n=%h Seg_n=%h Shown_Word=%h Frame_Done=%b", Digit_n, Seg_n, Shown_Word, Frame_Done);
        Reset = 1'b0;

        // ---- Scenario 1: first latch 32 edges after reset release ----
        for (int i = 0; i < 7; i++) begin
            tick(vecs[i].ticks);
            check($sformatf("vec%0d_digit", i), {24'd0, Digit_n}, {24'd0, vecs[i].digit});
            check($sformatf("vec%0d_seg", i),   {25'd0, Seg_n},   {25'd0, vecs[i].seg});
            check($sformatf("vec%0d_shown", i), Shown_Word,       vecs[i].shown);
            check($sformatf("vec%0d_fd", i),    {31'd0, Frame_Done}, {31'd0, vecs[i].fd});
            $display("vec%0d: Digit_n=%h Seg_n=%h Shown_Word=%h Frame_Done=%b", i, Digit_n, Seg_n, Shown_Word, Frame_Done);
        end

        // ---- Scenario 2: Hold across a boundary, then release ----
        Hold = 1'b1;
        HexDisplay32Bits = 32'hDEADBEEF;
        tick(FRAME);
        check("hold_shown", Shown_Word, 32'h12345678);
        check("hold_seg",   {25'd0, Seg_n}, 32'h00);
        check("hold_fd",    {31'd0, Frame_Done}, 32'h1);
        $display("hold frame: Shown_Word=%h Seg_n=%h Frame_Done=%b", Shown_Word, Seg_n, Frame_Done);
        // Release Hold, and pulse it mid-frame: only the boundary sample counts.
        Hold = 1'b0;
        tick(10);
        Hold = 1'b1;
        tick(5);
        Hold = 1'b0;
        tick(FRAME - 15);
        check("release_shown", Shown_Word, 32'hDEADBEEF);
        check("release_seg",   {25'd0, Seg_n}, 32'h0E);
        check("release_digit", {24'd0, Digit_n}, 32'hFE);
        $display("release frame: Shown_Word=%h Seg_n=%h Digit_n=%h", Shown_Word, Seg_n, Digit_n);

        // ---- Scenario 3: free run for 5 frames ----
        word = 32'hDEADBEEF;
        pulses = 0;
        last_pulse = 0;
        for (int i = 1; i <= 5 * FRAME; i++) begin
            tick(1);
            k = (i / SCAN_DIV) % 8;
            one_hot = 8'b1 << k;
            exp_digit = ~one_hot;
            nib = 4'((word >> (4 * k)) & 32'hF);
            check("run_digit", {24'd0, Digit_n}, {24'd0, exp_digit});
            check("run_seg",   {25'd0, Seg_n},   {25'd0, seg_of(nib)});
            check("run_fd",    {31'd0, Frame_Done}, {31'd0, ((i % FRAME) == 0)});
            if (Frame_Done === 1'b1) begin
                pulses++;
                check("run_spacing", i - last_pulse, FRAME);
                check("run_fd_digit", {24'd0, Digit_n}, 32'hFE);
                last_pulse = i;
            end
        end
        check("run_pulses", pulses, 5);
        $display("free run: %0d Frame_Done pulses", pulses);

        // ---- Scenario 4: reset mid-frame at digit 5 ----
        tick(5 * SCAN_DIV);
        check("pre_reset_digit", {24'd0, Digit_n}, 32'hDF);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        check("midreset_digit", {24'd0, Digit_n}, 32'hFE);
        check("midreset_seg",   {25'd0, Seg_n},   32'h40);
        check("midreset_shown", Shown_Word,       32'h0);
        check("midreset_fd",    {31'd0, Frame_Done}, 32'h0);
        $display("mid-frame reset: Digit_n=%h Seg_n=%h Shown_Word=%h", Digit_n, Seg_n, Shown_Word);

        // Reset coinciding with a boundary edge: reset wins, no pulse.
        tick(FRAME - 1);
        check("pre_bnd_digit", {24'd0, Digit_n}, 32'h7F);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        check("bndreset_fd",    {31'd0, Frame_Done}, 32'h0);
        check("bndreset_shown", Shown_Word,       32'h0);
        check("bndreset_digit", {24'd0, Digit_n}, 32'hFE);
        $display("boundary reset: Frame_Done=%b Shown_Word=%h", Frame_Done, Shown_Word);

        // ---- Scenarios 5/6: leading-zero handling on 32'h000000A0 ----
        HexDisplay32Bits = 32'h000000A0;
        tick(FRAME);
        check("lz_shown", Shown_Word, 32'h000000A0);
        for (int dgt = 0; dgt < 8; dgt++) begin
            if (dgt != 0) tick(SCAN_DIV);
            check($sformatf("lz_d%0d", dgt), {25'd0, Seg_n},
                  (dgt == 0) ? 32'h40 : (dgt == 1) ? 32'h08 : {25'd0, lead_exp});
            $display("word 000000A0 digit %0d: Seg_n=%h", dgt, Seg_n);
        end
        HexDisplay32Bits = 32'h0;
        tick(SCAN_DIV);
        check("zero_shown", Shown_Word, 32'h0);
        for (int dgt = 0; dgt < 8; dgt++) begin
            if (dgt != 0) tick(SCAN_DIV);
            check($sformatf("zero_d%0d", dgt), {25'd0, Seg_n},
                  (dgt == 0) ? 32'h40 : {25'd0, lead_exp});
            $display("word 00000000 digit %0d: Seg_n=%h", dgt, Seg_n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
